// File: rtl/memory_cycle_if.sv
// memory_cycle_if -- data-memory port bundle between the memory stage and
// the data memory.
//   dmem_req    master->slave  access request
//   dmem_we     master->slave  1 = write
//   dmem_addr   master->slave  word-aligned byte address
//   dmem_wdata  master->slave  store data
//   dmem_gnt    slave->master  request accepted this cycle
//   dmem_rvalid slave->master  read data valid
//   dmem_rdata  slave->master  read data
interface memory_cycle_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/memory_cycle.sv
// memory_cycle -- RV32I memory stage with request/grant/response data port
// and the M/W pipeline register.
//   clk, rst            rising-edge clock, synchronous active-high reset
//   RegWriteM..ALU_ResultM  M-stage control/data bundle from execute
//   dmem                data-memory port (memory_cycle_if.master)
//   StallM              holds E/M register and upstream stages
//   *W                  registered M/W outputs to writeback
// Optional feature: define MEM_MISALIGN_TRAP_EN to turn misaligned memory
// ops into a no-access MisalignW flag instead of a containing-word access.
module memory_cycle (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [4:0]            RD_M,
  input  logic [31:0]           PCPlus4M,
  input  logic [31:0]           WriteDataM,
  input  logic [31:0]           ALU_ResultM,
  memory_cycle_if.master        dmem,
  output logic                  StallM,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [4:0]            RD_W,
  output logic [31:0]           PCPlus4W,
  output logic [31:0]           ALU_ResultW,
  output logic [31:0]           ReadDataW,
  output logic                  MisalignW
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t state_q, state_d;

  logic is_store, is_load, is_mem, misalign;
  logic req, stall;

  logic        reg_write_q,   reg_write_d;
  logic [1:0]  result_src_q,  result_src_d;
  logic [4:0]  rd_q,          rd_d;
  logic [31:0] pc_plus4_q,    pc_plus4_d;
  logic [31:0] alu_result_q,  alu_result_d;
  logic [31:0] read_data_q,   read_data_d;

  // Store takes priority when both store and load encodings are present.
  assign is_store = MemWriteM;
  assign is_load  = !MemWriteM && (ResultSrcM == 2'b01);
  assign is_mem   = is_store || is_load;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = is_mem && (ALU_ResultM[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (is_mem && !misalign) begin
          if (!dmem.dmem_gnt)   state_d = ST_REQ;
          else if (is_load)     state_d = ST_WAIT;
        end
      end
      ST_REQ: begin
        if (dmem.dmem_gnt) state_d = is_load ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (dmem.dmem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req   = 1'b0;
    stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mem && !misalign) begin
          req   = 1'b1;
          stall = !(is_store && dmem.dmem_gnt);
        end
      end
      ST_REQ: begin
        req   = 1'b1;
        stall = !(is_store && dmem.dmem_gnt);
      end
      ST_WAIT: stall = !dmem.dmem_rvalid;
      default: ;
    endcase
    if (rst) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req && is_store;
  assign dmem.dmem_addr  = {ALU_ResultM[31:2], 2'b00};
  assign dmem.dmem_wdata = WriteDataM;
  assign StallM          = stall;

  // M/W register next values: a stall inserts a bubble (RegWrite cleared,
  // data fields held); ReadData only updates on load completion.
  always_comb begin
    reg_write_d  = 1'b0;
    result_src_d = result_src_q;
    rd_d         = rd_q;
    pc_plus4_d   = pc_plus4_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    if (!stall) begin
      reg_write_d  = RegWriteM && !misalign;
      result_src_d = ResultSrcM;
      rd_d         = RD_M;
      pc_plus4_d   = PCPlus4M;
      alu_result_d = ALU_ResultM;
      if (state_q == ST_WAIT) read_data_d = dmem.dmem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      result_src_q <= '0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_w_q, misalign_w_d;

  assign misalign_w_d = !stall && misalign;

  always_ff @(posedge clk) begin
    if (rst) misalign_w_q <= 1'b0;
    else     misalign_w_q <= misalign_w_d;
  end

  assign MisalignW = misalign_w_q;
`else
  assign MisalignW = 1'b0;
`endif

  assign RegWriteW   = reg_write_q;
  assign ResultSrcW  = result_src_q;
  assign RD_W        = rd_q;
  assign PCPlus4W    = pc_plus4_q;
  assign ALU_ResultW = alu_result_q;
  assign ReadDataW   = read_data_q;

endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle -- directed bench for memory_cycle: non-memory op, stalled
// store, multi-cycle load, reset mid-load, misaligned load, store/load
// encoding priority and back-to-back memory ops.
module tb_memory_cycle;
  logic        clk;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        StallM, RegWriteW, MisalignW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  int unsigned checks = 0;
  int unsigned errors = 0;

  memory_cycle_if dmem_if ();

  memory_cycle dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .PCPlus4M    (PCPlus4M),
    .WriteDataM  (WriteDataM),
    .ALU_ResultM (ALU_ResultM),
    .dmem        (dmem_if.master),
    .StallM      (StallM),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .RD_W        (RD_W),
    .PCPlus4W    (PCPlus4W),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .MisalignW   (MisalignW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [4:0] rd, input logic [31:0] pc4,
                       input logic [31:0] wd, input logic [31:0] alu);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = pc4; WriteDataM = wd; ALU_ResultM = alu;
  endtask

  task automatic set_bus(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    dmem_if.dmem_gnt = gnt; dmem_if.dmem_rvalid = rvalid; dmem_if.dmem_rdata = rdata;
  endtask

  int unsigned req_cnt, stall_cnt;

  initial begin
    // Reset with a store presented: port and stall must stay quiet.
    rst = 1'b1;
    set_m(1'b1, 1'b1, 2'b00, 5'd3, 32'h10, 32'h1111_1111, 32'h40);
    set_bus(1'b0, 1'b0, 32'h0);
    #1;
    check_eq("rst_req", dmem_if.dmem_req, 0);
    check_eq("rst_we", dmem_if.dmem_we, 0);
    check_eq("rst_stall", StallM, 0);
    tick(); tick();
    check_eq("rst_regwrite_w", RegWriteW, 0);
    check_eq("rst_alu_w", ALU_ResultW, 0);
    check_eq("rst_pc4_w", PCPlus4W, 0);
    check_eq("rst_rd_w", RD_W, 0);
    check_eq("rst_readdata_w", ReadDataW, 0);
    check_eq("rst_misalign_w", MisalignW, 0);
    rst = 1'b0;

    // ADD: single cycle to W, stray grant ignored
    set_m(1'b1, 1'b0, 2'b00, 5'd5, 32'h0000_0008, 32'h0, 32'h0000_0042);
    set_bus(1'b1, 1'b0, 32'h0);
    #1;
    check_eq("add_stall", StallM, 0);
    check_eq("add_req", dmem_if.dmem_req, 0);
    tick();
    check_eq("add_alu_w", ALU_ResultW, 32'h42);
    check_eq("add_rd_w", RD_W, 5);
    check_eq("add_regwrite_w", RegWriteW, 1);
    check_eq("add_pc4_w", PCPlus4W, 32'h8);
    check_eq("add_resultsrc_w", ResultSrcW, 0);
    check_eq("add_readdata_hold", ReadDataW, 0);

    // Store to 0x100, granted on the third cycle
    set_m(1'b0, 1'b1, 2'b00, 5'd0, 32'h0000_000C, 32'hDEAD_BEEF, 32'h0000_0100);
    req_cnt = 0; stall_cnt = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      set_bus(i == 2, 1'b0, 32'h0);
      #1;
      if (dmem_if.dmem_req) req_cnt++;
      if (StallM) stall_cnt++;
      check_eq("st_we", dmem_if.dmem_we, 1);
      check_eq("st_addr", dmem_if.dmem_addr, 32'h100);
      check_eq("st_wdata", dmem_if.dmem_wdata, 32'hDEAD_BEEF);
      tick();
      if (i < 2) begin
        check_eq("st_bubble_regwrite", RegWriteW, 0);
        check_eq("st_bubble_pc4_hold", PCPlus4W, 32'h8);
        check_eq("st_bubble_alu_hold", ALU_ResultW, 32'h42);
      end
    end
    check_eq("st_req_cycles", req_cnt, 3);
    check_eq("st_stall_cycles", stall_cnt, 2);
    check_eq("st_alu_w", ALU_ResultW, 32'h100);
    check_eq("st_pc4_w", PCPlus4W, 32'hC);
    check_eq("st_regwrite_w", RegWriteW, 0);

    // Load from 0x204: immediate grant, rvalid three cycles later
    set_m(1'b1, 1'b0, 2'b01, 5'd7, 32'h0000_0010, 32'h0, 32'h0000_0204);
    stall_cnt = 0;
    set_bus(1'b1, 1'b0, 32'h0);
    #1;
    check_eq("ld_req", dmem_if.dmem_req, 1);
    check_eq("ld_we", dmem_if.dmem_we, 0);
    check_eq("ld_addr", dmem_if.dmem_addr, 32'h204);
    if (StallM) stall_cnt++;
    tick();
    check_eq("ld_bubble_regwrite", RegWriteW, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      // grant during WAIT must be ignored
      set_bus(i == 0, i == 2, (i == 2) ? 32'h1234_5678 : 32'hFFFF_FFFF);
      #1;
      check_eq("ld_wait_req", dmem_if.dmem_req, 0);
      if (StallM) stall_cnt++;
      tick();
      if (i < 2) check_eq("ld_wait_regwrite", RegWriteW, 0);
    end
    check_eq("ld_stall_cycles", stall_cnt, 3);
    check_eq("ld_readdata_w", ReadDataW, 32'h1234_5678);
    check_eq("ld_regwrite_w", RegWriteW, 1);
    check_eq("ld_rd_w", RD_W, 7);
    check_eq("ld_resultsrc_w", ResultSrcW, 1);

    // Reset while in WAIT, then spurious rvalid
    set_m(1'b1, 1'b0, 2'b01, 5'd9, 32'h0000_0014, 32'h0, 32'h0000_0300);
    set_bus(1'b1, 1'b0, 32'h0);
    tick();
    rst = 1'b1;
    set_bus(1'b0, 1'b0, 32'h0);
    #1;
    check_eq("rstw_stall", StallM, 0);
    check_eq("rstw_req", dmem_if.dmem_req, 0);
    tick();
    rst = 1'b0;
    check_eq("rstw_readdata_w", ReadDataW, 0);
    check_eq("rstw_rd_w", RD_W, 0);
    check_eq("rstw_regwrite_w", RegWriteW, 0);
    set_m(1'b0, 1'b0, 2'b00, 5'd1, 32'h0000_0018, 32'h0, 32'h0000_0055);
    set_bus(1'b0, 1'b1, 32'h0000_0BAD);
    #1;
    check_eq("spur_stall", StallM, 0);
    tick();
    check_eq("spur_readdata_w", ReadDataW, 0);
    check_eq("spur_alu_w", ALU_ResultW, 32'h55);

    // Misaligned load at 0x202
    set_m(1'b1, 1'b0, 2'b01, 5'd4, 32'h0000_001C, 32'h0, 32'h0000_0202);
    set_bus(1'b1, 1'b0, 32'h0);
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    check_eq("mis_req", dmem_if.dmem_req, 0);
    check_eq("mis_stall", StallM, 0);
    tick();
    check_eq("mis_misalign_w", MisalignW, 1);
    check_eq("mis_regwrite_w", RegWriteW, 0);
    check_eq("mis_alu_w", ALU_ResultW, 32'h202);
    set_m(1'b0, 1'b0, 2'b00, 5'd0, 32'h0000_0020, 32'h0, 32'h0);
    set_bus(1'b0, 1'b0, 32'h0);
    tick();
    check_eq("mis_pulse_end", MisalignW, 0);
`else
    check_eq("mis_req", dmem_if.dmem_req, 1);
    check_eq("mis_addr", dmem_if.dmem_addr, 32'h200);
    tick();
    set_bus(1'b0, 1'b1, 32'hCAFE_F00D);
    #1;
    check_eq("mis_stall_rvalid", StallM, 0);
    tick();
    check_eq("mis_readdata_w", ReadDataW, 32'hCAFE_F00D);
    check_eq("mis_regwrite_w", RegWriteW, 1);
    check_eq("mis_misalign_w", MisalignW, 0);
`endif

    // Store encoding wins over load encoding; immediate grant, no stall
    set_m(1'b1, 1'b1, 2'b01, 5'd6, 32'h0000_0024, 32'hA5A5_5A5A, 32'h0000_0400);
    set_bus(1'b1, 1'b0, 32'h0);
    #1;
    check_eq("stld_we", dmem_if.dmem_we, 1);
    check_eq("stld_stall", StallM, 0);
    tick();
    check_eq("stld_pc4_w", PCPlus4W, 32'h24);
    check_eq("stld_resultsrc_w", ResultSrcW, 1);

    // Back-to-back load: grant after one cycle, rvalid right after grant
    set_m(1'b1, 1'b0, 2'b01, 5'd8, 32'h0000_0028, 32'h0, 32'h0000_0408);
    set_bus(1'b0, 1'b0, 32'h0);
    #1;
    check_eq("b2b_req", dmem_if.dmem_req, 1);
    check_eq("b2b_stall", StallM, 1);
    tick();
    set_bus(1'b1, 1'b0, 32'h0);
    #1;
    check_eq("b2b_req_hold", dmem_if.dmem_req, 1);
    tick();
    set_bus(1'b0, 1'b1, 32'h0BAD_F00D);
    #1;
    check_eq("b2b_stall_rvalid", StallM, 0);
    tick();
    check_eq("b2b_readdata_w", ReadDataW, 32'h0BAD_F00D);
    check_eq("b2b_rd_w", RD_W, 8);
    set_bus(1'b0, 1'b0, 32'h0);
    set_m(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    #1;
    check_eq("b2b_idle_stall", StallM, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory stage of the five-stage RV32I pipeline. Takes the M-stage control and data bundle produced by the execute stage and, for loads and stores, runs a request/grant/response handshake with the data-memory port. Holds the pipeline through `StallM` while an access is outstanding. Registers the result into the M/W pipeline register that feeds writeback.

## Interface
- No parameters. Widths are fixed: XLEN 32, register index 5.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `RegWriteM`  in  1  instruction writes the register file.
- `MemWriteM`  in  1  instruction is a store.
- `ResultSrcM`  in  2  writeback select: 00 ALU, 01 load data, 10 PC+4; 01 marks a load.
- `RD_M`  in  5  destination register.
- `PCPlus4M`  in  32  PC+4 of the instruction.
- `WriteDataM`  in  32  store data.
- `ALU_ResultM`  in  32  effective address or ALU result.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word address, `{ALU_ResultM[31:2],2'b00}`.
- `dmem_wdata`  out  32  equal to `WriteDataM`.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  32  read data.
- `StallM`  out  1  hold the E/M register and all upstream stages.
- `RegWriteW`  out  1  registered to W.
- `ResultSrcW`  out  2  registered to W.
- `RD_W`  out  5  registered to W.
- `PCPlus4W`  out  32  registered to W.
- `ALU_ResultW`  out  32  registered to W.
- `ReadDataW`  out  32  registered to W.
- `MisalignW`  out  1  misaligned-access flag to W; see Configuration.

## Operation
- Op class: store if `MemWriteM`; otherwise load if `ResultSrcM==2'b01`; otherwise non-memory. If both `MemWriteM` and `ResultSrcM==2'b01` are set, the op is a store.
- FSM states: IDLE, REQ (request issued, waiting for grant), WAIT (load granted, waiting for data).
- IDLE, non-memory op:
  - `dmem_req`=0, `StallM`=0.
  - W registers load the inputs at the edge.
  - `ReadDataW` holds its previous value.
- IDLE, memory op:
  - `dmem_req`=1 combinationally; `dmem_we`=1 for a store.
  - Store with `dmem_gnt`=1: done in this cycle. `StallM`=0, W loads, stay in IDLE.
  - Load with `dmem_gnt`=1: go to WAIT.
  - Any op with `dmem_gnt`=0: go to REQ.
  - `StallM`=1 in every IDLE memory-op case except the granted store.
- REQ:
  - `dmem_req` held at 1; address, write enable and write data stay stable (inputs are frozen by `StallM`).
  - `StallM`=1.
  - On grant: a store completes as in IDLE (`StallM`=0, W loads, go to IDLE); a load goes to WAIT.
- WAIT:
  - `dmem_req`=0.
  - `StallM`=1 until `dmem_rvalid`.
  - In the `dmem_rvalid` cycle: `StallM`=0, `ReadDataW`←`dmem_rdata`, other W registers load, go to IDLE.
- While `StallM`=1, the W registers take a bubble: `RegWriteW`=0, `MisalignW`=0, all other W fields hold their values.
- `dmem_rvalid` outside WAIT is ignored.
- `dmem_gnt` while `dmem_req`=0 is ignored.

## Timing
- Non-memory op: 1 cycle to W, no stall.
- Store granted in its first cycle: 1 cycle, no stall. Each cycle without grant adds one stall cycle.
- Load: grant cycle, then ≥1 WAIT cycle. `dmem_rvalid` is valid no earlier than the cycle after grant.
  - Minimum stall is 1 cycle (rvalid in the cycle after grant).
  - Result appears in W at the edge ending the rvalid cycle.
- Reset, sampled at the edge:
  - Next state is IDLE.
  - All W outputs are 0.
  - `dmem_req`, `dmem_we` and `StallM` are forced to 0 combinationally while `rst`=1.
- Reset during REQ or WAIT abandons the access. Any late `dmem_rvalid` is ignored because the state is IDLE.
- Back-to-back memory ops: the next op is evaluated in IDLE on the cycle after the previous op completes. No idle cycle is inserted.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A memory op with `ALU_ResultM[1:0]!=0` issues no request (`dmem_req`=0) and does not stall.
  - W loads with `RegWriteW`=0 and `MisalignW`=1 for one cycle.
- `MEM_MISALIGN_TRAP_EN` not defined:
  - `MisalignW` is tied to 0.
  - Low address bits are dropped, so the access goes to the containing word.

## Test plan
- ADD result `ALU_ResultM`=0x0000_0042, `RD_M`=5, `RegWriteM`=1 → next cycle `ALU_ResultW`=0x42, `RD_W`=5, `RegWriteW`=1; `StallM` never asserted.
- Store to 0x100, data 0xDEAD_BEEF, grant after 2 cycles → `dmem_req`=1 for 3 cycles with `dmem_we`=1, `dmem_addr`=0x100, `dmem_wdata`=0xDEADBEEF; `StallM`=1 for 2 cycles; one W update.
- Load from 0x204, immediate grant, rvalid 3 cycles later with 0x1234_5678 → `StallM`=1 for 3 cycles, `RegWriteW`=0 during the stall, then `ReadDataW`=0x12345678 with `RegWriteW`=1.
- `rst` pulsed for one cycle while in WAIT, then a spurious `dmem_rvalid` → all W outputs 0, state IDLE, rvalid ignored, `StallM`=0.
- Load at 0x202:
  - With `MEM_MISALIGN_TRAP_EN`: no `dmem_req`, `MisalignW`=1, `RegWriteW`=0.
  - Without: `dmem_addr`=0x200, normal load.
